neuron_mac: RTL

Single-neuron multiply-accumulate engine that consumes the synchronous weight ROM.
- Drives the ROM address.
- Pairs each returned weight with a streamed activation and accumulates the products.
- Adds a bias, applies ReLU and saturates to Q(INT_WIDTH).(FRAC_WIDTH).
- Sits between the input activation stream and the layer output collector; one instance per neuron.

---
 rtl/neuron_pkg.sv | 31 +++
 rtl/fixed_point_activation.sv | 38 +++
 rtl/neuron_mac.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types for the single-neuron MAC: fixed-point formats,
// FSM states and the width helpers used by the datapath.
package neuron_pkg;

  localparam int Q_INT  = 8;
  localparam int Q_FRAC = 8;
  localparam int Q_W    = Q_INT + Q_FRAC;

  typedef logic signed [Q_INT-1:-Q_FRAC] q_t;
  typedef logic signed [2*Q_W-1:0] prod_t;
  typedef logic signed [2*Q_W+$clog2(784)-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINAL,
    DONE
  } state_t;

  localparam q_t Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
  localparam q_t Q_MIN = '0;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_width(input int w, input int n);
    return 2 * w + addr_width(n);
  endfunction

endpackage

// File: rtl/fixed_point_activation.sv
// Combinational bias add, rescale, ReLU and saturation
// from the wide accumulator format back to the operand format.
module fixed_point_activation
  import neuron_pkg::*;
#(
  parameter int INT_WIDTH  = Q_INT,
  parameter int FRAC_WIDTH = Q_FRAC,
  parameter int ACC_WIDTH  = acc_width(Q_W, 784)
) (
  input  logic [ACC_WIDTH-1:0]            acc,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0] bias,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] y
);

  localparam int W  = INT_WIDTH + FRAC_WIDTH;
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};

  logic signed [SW-1:0] bias_ext;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] max_ext;

  always_comb begin
    bias_ext = SW'($signed(bias));
    // Bias is aligned to the product's 2*FRAC fraction first.
    sum      = SW'($signed(acc)) + (bias_ext <<< FRAC_WIDTH);
    shifted  = sum >>> FRAC_WIDTH;
    max_ext  = {{(SW-W){1'b0}}, POS_MAX};
    y        = shifted[W-1:0];
    if (shifted < 0) begin
      y = '0;
    end else if (shifted > max_ext) begin
      y = POS_MAX;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate engine reading an external
// synchronous weight ROM, with bias, ReLU and saturation.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int INT_WIDTH  = Q_INT,
  parameter int FRAC_WIDTH = Q_FRAC,
  parameter int NUM_INPUTS = 784,
  localparam int W  = INT_WIDTH + FRAC_WIDTH,
  localparam int AW = addr_width(NUM_INPUTS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  bias,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] weight_num,
  input  logic [W-1:0]  weight,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int PW = 2 * W;
  localparam int AC = acc_width(W, NUM_INPUTS);
  localparam logic [AW-1:0] LAST = AW'(NUM_INPUTS - 1);

  state_t state;
  state_t state_nx;

  logic [AW-1:0]        idx;
  logic signed [W-1:0]  x_d;
  logic [W-1:0]         bias_q;
  logic                 v_d;
  logic signed [AC-1:0] acc;
  logic signed [AC-1:0] acc_sum;
  logic signed [AC-1:0] prod_ext;
  logic signed [PW-1:0] prod;
  logic [W-1:0]         act;
  logic                 accept;
  logic                 handshake;
  logic                 last_in;

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign weight_num = idx;
  assign accept     = in_valid & in_ready;
  assign handshake  = out_valid & out_ready;
  assign last_in    = accept & (idx == LAST);

  // The ROM answers one cycle after the accept edge, so x_d
  // and weight line up in the cycle after each accept.
  always_comb begin
    prod     = $signed(x_d) * $signed(weight);
    prod_ext = '0;
    if (v_d) begin
      prod_ext = AC'(prod);
    end
    acc_sum = acc + prod_ext;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = ACCUM;
        end
      end
      ACCUM: begin
        if (last_in) begin
          state_nx = FINAL;
        end
      end
      FINAL: begin
        state_nx = DONE;
      end
      DONE: begin
        if (handshake) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  fixed_point_activation #(
    .INT_WIDTH  (INT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .ACC_WIDTH  (AC)
  ) u_act (
    .acc  (acc_sum),
    .bias (bias_q),
    .y    (act)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_d <= '0;
      v_d <= 1'b0;
    end else begin
      v_d <= accept;
      if (accept) begin
        x_d <= in_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      acc      <= '0;
      bias_q   <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx    <= '0;
            acc    <= '0;
            bias_q <= bias;
          end
        end
        ACCUM: begin
          acc <= acc_sum;
          if (accept && !last_in) begin
            idx <= idx + AW'(1);
          end
        end
        FINAL: begin
          out_data <= act;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
